// File: rtl/wca_expansion_port_driver_pkg.sv
// wca_expansion_port_driver_pkg: shared mode codes, pin constants and widths for the EP output driver.
package wca_expansion_port_driver_pkg;
    localparam int EP_CNT_W = 16;
    localparam int NPINS = 3;
    localparam logic [1:0] EP_PIN_ALL = 2'd3;
    typedef enum logic [1:0] {
        EP_MODE_LEVEL    = 2'd0,
        EP_MODE_PULSE    = 2'd1,
        EP_MODE_SQUARE   = 2'd2,
        EP_MODE_RESERVED = 2'd3
    } ep_mode_e;
endpackage

// File: rtl/wca_ep_pin_driver.sv
// wca_ep_pin_driver: one expansion output pin with LEVEL, PULSE and SQUARE modes.
// Ports: clk, reset (async, active-low), load (accept command), mode/level/count (command fields),
//        pin_out (registered pin), busy (pulse in progress), done (1-cycle pulse-complete strobe).
module wca_ep_pin_driver
    import wca_expansion_port_driver_pkg::*;
#(
    parameter int CNT_W = EP_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic             level,
    input  logic [CNT_W-1:0] count,
    output logic             pin_out,
    output logic             busy,
    output logic             done
);
    ep_mode_e mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, reload_q, reload_d;
    logic out_d, done_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= EP_MODE_LEVEL;
            cnt_q    <= '0;
            reload_q <= '0;
            pin_out  <= 1'b0;
            done     <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            pin_out  <= out_d;
            done     <= done_d;
        end
    end
    // A load always wins, so a pulse ending on the same cycle never raises done.
    always_comb begin
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        out_d    = pin_out;
        done_d   = 1'b0;
        if (load) begin
            mode_d   = (mode == EP_MODE_PULSE || mode == EP_MODE_SQUARE) ? ep_mode_e'(mode) : EP_MODE_LEVEL;
            cnt_d    = count;
            reload_d = count;
            out_d    = level;
        end else if (mode_q != EP_MODE_LEVEL) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                // pin_out still holds the active/start level, so inverting it ends the pulse or toggles the square
                out_d  = ~pin_out;
                cnt_d  = reload_q;
                mode_d = (mode_q == EP_MODE_PULSE) ? EP_MODE_LEVEL : mode_q;
                done_d = (mode_q == EP_MODE_PULSE);
            end
        end
    end
    assign busy = (mode_q == EP_MODE_PULSE);
endmodule

// File: rtl/wca_expansion_port_driver.sv
// wca_expansion_port_driver: drives the expansion-port output pins from qualified host commands.
// Ports: clk, reset (async, active-low), ctrl1/ctrl2 (write qualifiers), cmd_pin (0..2, 3=all),
//        cmd_mode/cmd_level/cmd_count (command), epout (pins), busy (pulse active), done (pulse complete).
module wca_expansion_port_driver
    import wca_expansion_port_driver_pkg::*;
#(
    parameter int CNT_W = EP_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl1,
    input  logic             ctrl2,
    input  logic [1:0]       cmd_pin,
    input  logic [1:0]       cmd_mode,
    input  logic             cmd_level,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [NPINS-1:0] epout,
    output logic [NPINS-1:0] busy,
    output logic [NPINS-1:0] done
);
    logic [NPINS-1:0] load;
    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        assign load[i] = ctrl1 & ctrl2 & (cmd_pin == 2'(i) || cmd_pin == EP_PIN_ALL);
        wca_ep_pin_driver #(.CNT_W(CNT_W)) u_pin (
            .clk    (clk),
            .reset  (reset),
            .load   (load[i]),
            .mode   (cmd_mode),
            .level  (cmd_level),
            .count  (cmd_count),
            .pin_out(epout[i]),
            .busy   (busy[i]),
            .done   (done[i])
        );
    end
endmodule

// File: tb/tb_wca_expansion_port_driver.sv
// tb_wca_expansion_port_driver: vector table, corner sequences and random traffic against a time-based model.
module tb_wca_expansion_port_driver;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ctrl1 = 1'b0, ctrl2 = 1'b0, cmd_level = 1'b0;
    logic [1:0] cmd_pin = '0, cmd_mode = '0;
    logic [15:0] cmd_count = '0;
    logic [2:0] epout, busy, done;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_mode [3];
    int m_t0 [3];
    int m_cnt [3];
    logic m_lvl [3];

    wca_expansion_port_driver #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ctrl1(ctrl1), .ctrl2(ctrl2), .cmd_pin(cmd_pin),
        .cmd_mode(cmd_mode), .cmd_level(cmd_level), .cmd_count(cmd_count),
        .epout(epout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic c1, c2;
        logic [1:0] pin, mode;
        logic lvl;
        logic [15:0] cnt;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_lvl[i] = 1'b0; m_cnt[i] = 0; m_t0[i] = 0;
        end
    endtask

    // Output of each pin follows from how many edges have passed since its last command.
    function automatic logic [8:0] model();
        logic [2:0] o, b, d;
        int k;
        o = '0; b = '0; d = '0;
        for (int i = 0; i < 3; i++) begin
            k = cyc - m_t0[i];
            if (m_mode[i] == 1) begin
                b[i] = (k <= m_cnt[i]);
                o[i] = b[i] ? m_lvl[i] : ~m_lvl[i];
                d[i] = (k == m_cnt[i] + 1);
            end else if (m_mode[i] == 2) begin
                o[i] = m_lvl[i] ^ ((k / (m_cnt[i] + 1)) % 2 == 1);
            end else begin
                o[i] = m_lvl[i];
            end
        end
        return {o, b, d};
    endfunction

    task automatic step(input logic c1, input logic c2, input logic [1:0] p, input logic [1:0] m,
                        input logic l, input logic [15:0] c);
        ctrl1 = c1; ctrl2 = c2; cmd_pin = p; cmd_mode = m; cmd_level = l; cmd_count = c;
        @(posedge clk);
        cyc++;
        if (reset && c1 && c2)
            for (int i = 0; i < 3; i++)
                if (p == 2'd3 || int'(p) == i) begin
                    m_mode[i] = (m == 2'd3) ? 0 : int'(m);
                    m_lvl[i] = l; m_cnt[i] = int'(c); m_t0[i] = cyc;
                end
        #1;
        chk("model", {epout, busy, done}, model());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0);
    endtask

    initial begin
        logic [6:0] sq;
        logic seen;
        mreset();
        tbl[0]  = '{1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 16'd0, 9'b000_000_000};
        tbl[1]  = '{1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 16'd0, 9'b010_000_000};
        tbl[2]  = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 16'd0, 9'b010_000_000};
        tbl[3]  = '{1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 16'd4, 9'b011_001_000};
        for (int i = 4; i < 8; i++) tbl[i] = '{1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0, 9'b011_001_000};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0, 9'b010_000_001};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0, 9'b010_000_000};
        tbl[10] = '{1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 16'd0, 9'b011_001_000};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0, 9'b010_000_001};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 16'd0, 9'b010_000_000};
        tbl[13] = '{1'b1, 1'b1, 2'd3, 2'd3, 1'b0, 16'd5, 9'b000_000_000};

        // Held in reset: random commands must not move anything.
        for (int i = 0; i < 8; i++) begin
            step(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom_range(0, 5)));
            chk("reset_hold", {epout, busy, done}, 9'd0);
        end
        #2 reset = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].c1, tbl[i].c2, tbl[i].pin, tbl[i].mode, tbl[i].lvl, tbl[i].cnt);
            chk($sformatf("table[%0d]", i), {epout, busy, done}, tbl[i].exp);
        end

        // Square on pin 2 then stop with LEVEL 1.
        sq = '0;
        step(1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 16'd2);
        sq = {sq[5:0], epout[2]};
        for (int i = 0; i < 6; i++) begin
            idle(1);
            sq = {sq[5:0], epout[2]};
        end
        chk("square_wave", {2'b00, sq}, 9'b00_0001110);
        step(1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 16'd0);
        idle(4);
        chk("square_stop", {8'd0, epout[2]}, 9'd1);

        // Preempt a long pulse with LEVEL 0: no done ever.
        step(1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 16'd10);
        idle(2);
        step(1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 16'd0);
        chk("preempt_low", {8'd0, epout[0]}, 9'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            seen = seen | done[0];
        end
        chk("preempt_nodone", {8'd0, seen}, 9'd0);

        // Command lands on the pulse-completion edge.
        step(1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 16'd2);
        idle(2);
        step(1'b1, 1'b1, 2'd1, 2'd0, 1'b1, 16'd0);
        chk("collide", {6'd0, epout[1], busy[1], done[1]}, 9'b000000_100);
        idle(2);

        // Broadcast square in lockstep, then async reset mid-run.
        step(1'b1, 1'b1, 2'd3, 2'd2, 1'b0, 16'd1);
        for (int i = 0; i < 7; i++) begin
            idle(1);
            chk("bcast_lockstep", {6'd0, epout}, (epout[0] ? 9'd7 : 9'd0));
        end
        #2 reset = 1'b0;
        #1 chk("async_reset", {epout, busy, done}, 9'd0);
        mreset();
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'($urandom), 2'($urandom), 1'b1, 16'($urandom_range(0, 5)));
        #2 reset = 1'b1;
        idle(4);
        chk("post_reset_idle", {epout, busy, done}, 9'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom_range(0, 6)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
